aud_player: RTL and testbench
=============================

Name: aud_player

Overview:
- I2S-style playback engine: the transmit counterpart of the audio recorder.
- Reads 16-bit samples from SRAM at a sequential address.
- Serializes each sample MSB-first onto the codec DAC data line, one sample per LRC period, aligned to the LRC rising edge.
- Sits between the SRAM read port and the WM8731 DACDAT pin; controlled by the same start/pause/stop buttons as the recorder.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width; also the number of bits shifted per sample.

Ports:
- i_clk  in  1  codec bit clock (BCLK); all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lrc  in  1  codec DACLRCK; a sample frame starts at its rising edge.
- i_start  in  1  begin or resume playback (level; sampled each cycle).
- i_pause  in  1  pause playback, keep address.
- i_stop  in  1  stop playback, return address to 0.
- i_loop  in  1  1: wrap to address 0 after end address; 0: stop at end.
- i_end_addr  in  ADDR_W  last valid sample address (inclusive).
- i_data  in  DATA_W  SRAM read data for o_address; valid whenever o_address has been stable for 1 cycle.
- o_address  out  ADDR_W  SRAM read address.
- o_dacdat  out  1  serial DAC data.
- o_busy  out  1  high in S_WAIT, S_SEND and S_NEXT.
- o_done  out  1  one-cycle pulse when non-loop playback passes i_end_addr.

Behaviour:
Registers:
- state_r, addr_r, shift_r[DATA_W-1:0], bitcnt_r[3:0], lrc_r (i_lrc delayed one cycle), done_r.
- Reset values: state=S_IDLE, addr=0, shift=0, bitcnt=0, lrc_r=0, done=0.
- At reset: o_address=0, o_dacdat=0, o_busy=0, o_done=0.
- Edge detect: lrc_rise = !lrc_r && i_lrc. lrc_r updates every cycle in every state.

States and transitions:
- S_IDLE: o_dacdat=0. If i_start goes to S_WAIT.
- S_PAUSE: identical to S_IDLE except reached via pause. addr is held. i_start goes to S_WAIT and playback resumes at the same addr.
- S_WAIT:
  - o_address=addr is held stable.
  - On lrc_rise: shift <= i_data, bitcnt <= 0, go to S_SEND.
  - o_dacdat=0 while waiting.
- S_SEND:
  - o_dacdat = shift[DATA_W-1], registered output.
  - The MSB therefore appears in the first cycle after the lrc_rise cycle.
  - Each cycle: shift <= shift<<1, bitcnt+1.
  - When bitcnt==DATA_W-1 (16th bit driven) go to S_NEXT.
  - Exactly 16 bits are emitted, back-to-back.
- S_NEXT (1 cycle), o_dacdat=0:
  - If addr != i_end_addr: addr+1, go to S_WAIT.
  - If addr == i_end_addr and i_loop=1: addr <= 0, go to S_WAIT.
  - If addr == i_end_addr and i_loop=0: addr <= 0, o_done pulses next cycle, go to S_IDLE.

Controls:
- Priority is i_stop > i_pause > FSM.
- i_stop in any state: next state S_IDLE, addr <= 0, shift <= 0, bitcnt <= 0; o_dacdat=0 next cycle.
- i_pause in any non-idle state: next state S_PAUSE, addr unchanged. An in-flight sample is abandoned and the same address is replayed in full on resume.
- i_start while already busy: ignored.
- i_start and i_pause together: pause wins.

Boundaries:
- lrc_rise while in S_SEND or S_NEXT: ignored. The codec frame of at least 32 BCLK/LRC period guarantees none occurs in correct operation.
- addr arithmetic is ADDR_W bits. If i_end_addr = 2^ADDR_W-1, the increment wraps naturally to 0, identical to loop handling.
- i_end_addr=0: each frame plays address 0, then loops or finishes.
- i_end_addr changed mid-playback: takes effect at the next S_NEXT compare.
- Async reset mid-sample: all outputs go to reset values immediately.

Test Plan:
- Reset, i_end_addr=2, i_loop=0, SRAM[0..2]=16'hA5A5/16'h8001/16'hFFFF, i_start for 1 cycle, LRC period 64 clk -> o_dacdat shows 1010010110100101, 1000000000000001, 1111111111111111, each starting 1 cycle after an LRC rise. o_address steps 0,1,2; o_done pulses once; addr returns 0; o_busy falls.
- Same setup with i_loop=1 over 4 frames -> addresses 0,1,2,0; samples repeat 16'hA5A5 on frame 4; o_done never asserts.
- i_pause asserted during bit 7 of the address-1 sample, then i_start 200 cycles later -> o_dacdat=0 while paused; o_address stays 1; after resume the full 16'h8001 is sent from its MSB.
- i_stop during address-2 playback -> next cycle o_dacdat=0, o_address=0, o_busy=0; a later i_start plays 16'hA5A5 first.
- i_stop and i_pause asserted in the same cycle while busy -> S_IDLE with address 0 (stop wins). Also: i_start held high during playback does not disturb the address sequence.
- Async reset pulse in the middle of a sample -> o_dacdat, o_address, o_busy and o_done go to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/aud_player_if.sv
// rtl/aud_player_if.sv - SRAM read port between the playback engine and sample memory
interface aud_player_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;

  modport master (output address, input data);
  modport slave  (input address, output data);
endinterface

// File: rtl/aud_player.sv
// rtl/aud_player.sv - I2S-style playback engine: SRAM samples serialized MSB-first onto DACDAT
module aud_player #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_player_if.master      sram,
  output logic              o_dacdat,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_WAIT, S_SEND, S_NEXT} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  state_t              state_r, state_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic [DATA_W-1:0]   shift_r, shift_n;
  logic [3:0]          bitcnt_r, bitcnt_n;
  logic                lrc_r;
  logic                done_r, done_n;
  logic                lrc_rise;

  assign lrc_rise = !lrc_r && i_lrc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= S_IDLE;
      addr_r   <= '0;
      shift_r  <= '0;
      bitcnt_r <= '0;
      lrc_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      addr_r   <= addr_n;
      shift_r  <= shift_n;
      bitcnt_r <= bitcnt_n;
      lrc_r    <= i_lrc;
      done_r   <= done_n;
    end
  end

  // Stop beats pause beats the normal sequence; pause leaves addr alone so the sample replays.
  always_comb begin
    state_n  = state_r;
    addr_n   = addr_r;
    shift_n  = shift_r;
    bitcnt_n = bitcnt_r;
    done_n   = 1'b0;
    if (i_stop) begin
      state_n  = S_IDLE;
      addr_n   = '0;
      shift_n  = '0;
      bitcnt_n = '0;
    end else if (i_pause && state_r != S_IDLE) begin
      state_n = S_PAUSE;
    end else begin
      case (state_r)
        S_IDLE, S_PAUSE: begin
          if (i_start && !i_pause) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (lrc_rise) begin
            shift_n  = sram.data;
            bitcnt_n = '0;
            state_n  = S_SEND;
          end
        end
        S_SEND: begin
          shift_n  = shift_r << 1;
          bitcnt_n = bitcnt_r + 4'd1;
          if (bitcnt_r == LAST_BIT) state_n = S_NEXT;
        end
        S_NEXT: begin
          if (addr_r != i_end_addr) begin
            addr_n  = addr_r + ADDR_W'(1);
            state_n = S_WAIT;
          end else begin
            addr_n = '0;
            if (i_loop) begin
              state_n = S_WAIT;
            end else begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign sram.address = addr_r;
  assign o_dacdat     = (state_r == S_SEND) && shift_r[DATA_W-1];
  assign o_busy       = (state_r == S_WAIT) || (state_r == S_SEND) || (state_r == S_NEXT);
  assign o_done       = done_r;

endmodule

// File: tb/tb_aud_player.sv
// tb/tb_aud_player.sv - randomized self-checking bench for aud_player against a frame-level model
module tb_aud_player;

  logic        clk;
  logic        rst_n;
  logic        lrc;
  logic        start;
  logic        pause;
  logic        stop;
  logic        loop_en;
  logic [19:0] end_addr;
  logic        dacdat;
  logic        busy;
  logic        done;

  logic [15:0] mem [64];
  int          lrc_cnt;
  int          done_cnt;
  int          n_checks;
  int          n_fail;

  aud_player_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  assign bus.data = mem[bus.address[5:0]];

  aud_player #(.ADDR_W(20), .DATA_W(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lrc      (lrc),
    .i_start    (start),
    .i_pause    (pause),
    .i_stop     (stop),
    .i_loop     (loop_en),
    .i_end_addr (end_addr),
    .sram       (bus),
    .o_dacdat   (dacdat),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running 64-clock LRC frame, updated away from the active edge.
  initial begin
    lrc_cnt = 40;
    lrc     = 1'b0;
  end
  always @(negedge clk) begin
    lrc_cnt = (lrc_cnt == 63) ? 0 : lrc_cnt + 1;
    lrc     = (lrc_cnt < 32);
  end

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  // Returns right after the clock edge at which the DUT sees the LRC rise.
  task automatic wait_rise(output bit ok);
    logic prev;
    prev = lrc;
    ok   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (lrc && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = lrc;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] exp_w, input logic [19:0] exp_a);
    logic [15:0] w;
    bit          ok;
    w = '0;
    wait_rise(ok);
    if (!ok) begin
      check({tag, " lrc timeout"}, 32'd0, 32'd1);
      return;
    end
    #1;
    check({tag, " addr"}, 32'(bus.address), 32'(exp_a));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      w = {w[14:0], dacdat};
    end
    check({tag, " data"}, 32'(w), 32'(exp_w));
  endtask

  initial begin
    int          d0;
    bit          ok;
    bit          quiet;
    bit          held;
    logic [7:0]  part;
    logic [19:0] a;
    int          nframes;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    end_addr = 20'd2;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA5A5;
    mem[1] = 16'h8001;
    mem[2] = 16'hFFFF;

    repeat (3) tick();
    check("reset dacdat", 32'(dacdat), 32'd0);
    check("reset address", 32'(bus.address), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // One-shot playback of three samples
    d0 = done_cnt;
    pulse_start();
    check("wait busy", 32'(busy), 32'd1);
    check("wait dacdat", 32'(dacdat), 32'd0);
    expect_frame("once f0", 16'hA5A5, 20'd0);
    expect_frame("once f1", 16'h8001, 20'd1);
    expect_frame("once f2", 16'hFFFF, 20'd2);
    repeat (5) tick();
    check("once done pulses", 32'(done_cnt - d0), 32'd1);
    check("once addr back", 32'(bus.address), 32'd0);
    check("once busy low", 32'(busy), 32'd0);

    // Looping playback
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    expect_frame("loop f0", 16'hA5A5, 20'd0);
    expect_frame("loop f1", 16'h8001, 20'd1);
    expect_frame("loop f2", 16'hFFFF, 20'd2);
    expect_frame("loop f3", 16'hA5A5, 20'd0);
    check("loop no done", 32'(done_cnt - d0), 32'd0);
    do_stop();
    loop_en = 1'b0;

    // Pause on bit 7 of address 1, resume replays the whole sample
    d0 = done_cnt;
    pulse_start();
    expect_frame("pause f0", 16'hA5A5, 20'd0);
    wait_rise(ok);
    check("pause rise", 32'(ok), 32'd1);
    #1;
    part = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      part = {part[6:0], dacdat};
    end
    check("pause partial bits", 32'(part), 32'h80);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    quiet = 1'b1;
    held  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (dacdat !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      if (bus.address !== 20'd1) held = 1'b0;
      tick();
    end
    check("paused quiet", 32'(quiet), 32'd1);
    check("paused addr held", 32'(held), 32'd1);
    pulse_start();
    expect_frame("resume f1", 16'h8001, 20'd1);
    expect_frame("resume f2", 16'hFFFF, 20'd2);
    repeat (5) tick();
    check("resume done", 32'(done_cnt - d0), 32'd1);

    // Stop during address 2, then restart from the beginning
    pulse_start();
    expect_frame("stop f0", 16'hA5A5, 20'd0);
    expect_frame("stop f1", 16'h8001, 20'd1);
    wait_rise(ok);
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop dacdat", 32'(dacdat), 32'd0);
    check("stop address", 32'(bus.address), 32'd0);
    check("stop busy", 32'(busy), 32'd0);
    pulse_start();
    expect_frame("restart f0", 16'hA5A5, 20'd0);
    do_stop();

    // Stop and pause together: stop wins and clears the address
    pulse_start();
    expect_frame("sp f0", 16'hA5A5, 20'd0);
    wait_rise(ok);
    repeat (3) tick();
    stop  = 1'b1;
    pause = 1'b1;
    tick();
    stop  = 1'b0;
    pause = 1'b0;
    check("stop+pause address", 32'(bus.address), 32'd0);
    check("stop+pause busy", 32'(busy), 32'd0);
    tick();
    check("stop+pause stays idle", 32'(busy), 32'd0);

    // Start held high during playback does not disturb the sequence
    d0 = done_cnt;
    start = 1'b1;
    expect_frame("held f0", 16'hA5A5, 20'd0);
    expect_frame("held f1", 16'h8001, 20'd1);
    expect_frame("held f2", 16'hFFFF, 20'd2);
    start = 1'b0;
    repeat (5) tick();
    check("held done", 32'(done_cnt - d0), 32'd1);
    check("held busy low", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a sample
    pulse_start();
    expect_frame("arst f0", 16'hA5A5, 20'd0);
    wait_rise(ok);
    repeat (5) tick();
    check("arst pre busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst dacdat", 32'(dacdat), 32'd0);
    check("arst address", 32'(bus.address), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized rounds: random contents, end address and loop mode
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
      end_addr = 20'($urandom_range(0, 4));
      loop_en  = 1'($urandom_range(0, 1));
      nframes  = loop_en ? int'(end_addr) + 3 : int'(end_addr) + 1;
      d0 = done_cnt;
      a  = '0;
      pulse_start();
      for (int f = 0; f < nframes; f++) begin
        expect_frame($sformatf("rnd%0d f%0d", r, f), mem[a[5:0]], a);
        a = (a == end_addr) ? 20'd0 : a + 20'd1;
      end
      repeat (5) tick();
      check($sformatf("rnd%0d done", r), 32'(done_cnt - d0), loop_en ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d busy", r), 32'(busy), loop_en ? 32'd1 : 32'd0);
      do_stop();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
